// File: rtl/vram_arbiter.sv
// Video RAM arbiter: display refresh owns every visible p_tick cycle, the host
// read/write port gets all remaining cycles of the single-port synchronous RAM.
module vram_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int SCALE  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_data
);

  localparam int              SHIFT   = $clog2(SCALE);
  localparam int              PROD_W  = 10 + $clog2(FB_W) + 1;
  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W + 1)'(FB_W * FB_H);

  typedef enum logic [1:0] {IDLE, WAIT, RDWAIT, ACK} state_t;

  state_t state, next_state;

  logic              disp_slot, blank_slot;
  logic              disp_d, blank_d;
  logic [9:0]        col_q, row_q;
  logic [ADDR_W-1:0] disp_addr;
  logic              accept, host_issue;
  logic              cmd_we, cmd_oor;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Constant multiply by FB_W as a sum of shifted copies of the row index.
  function automatic logic [PROD_W-1:0] times_fb_w(input logic [9:0] row);
    logic [PROD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < PROD_W; i++)
      if (FB_W[i]) acc = acc + (PROD_W'(row) << i);
    return acc;
  endfunction

  assign disp_slot  = p_tick & video_on;
  assign blank_slot = p_tick & ~video_on;
  assign col_q      = pixel_x >> SHIFT;
  assign row_q      = pixel_y >> SHIFT;
  assign disp_addr  = ADDR_W'(times_fb_w(row_q) + PROD_W'(col_q));

  assign accept  = (state == IDLE) && host_req;
  assign cmd_oor = ({1'b0, cmd_addr} >= FB_SIZE);

  // NOTE: every output and next_state gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    host_issue = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    host_ack   = 1'b0;

    case (state)
      IDLE:    if (host_req) next_state = WAIT;
      WAIT:    if (!disp_slot) begin
                 host_issue = 1'b1;
                 next_state = cmd_we ? ACK : RDWAIT;
               end
      RDWAIT:  next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Display and host issue are mutually exclusive: WAIT only issues off-slot.
    if (!reset) begin
      host_ack = (state == ACK);
      if (disp_slot) begin
        ram_en   = 1'b1;
        ram_addr = disp_addr;
      end else if (host_issue && !cmd_oor) begin
        ram_en    = 1'b1;
        ram_we    = cmd_we;
        ram_addr  = cmd_addr;
        ram_wdata = cmd_we ? cmd_wdata : '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      disp_d     <= 1'b0;
      blank_d    <= 1'b0;
      pix_data   <= '0;
      host_rdata <= '0;
    end else begin
      state   <= next_state;
      disp_d  <= disp_slot;
      blank_d <= blank_slot;
      if (disp_d)       pix_data <= ram_rdata;
      else if (blank_d) pix_data <= '0;
      if (state == RDWAIT) host_rdata <= cmd_oor ? '0 : ram_rdata;
    end
  end

  // NOTE: the command holding registers carry no reset; they are only read
  // in WAIT/RDWAIT, which are reachable only after a fresh accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_we    <= host_we;
      cmd_addr  <= host_addr;
      cmd_wdata <= host_wdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: display addressing table, pixel pipeline,
// host transactions with exact latencies, reset mid-read and a partial frame sweep.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick, video_on;
  logic [9:0]  pixel_x, pixel_y;
  logic        host_req, host_we;
  logic [14:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [7:0]  pix_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM, one-clock read latency, with a preload port.
  logic [7:0]  mem [0:32767];
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [7:0]  pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .pix_data   (pix_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance to the next cycle and drive the sync-generator inputs 1 ns after the edge.
  task automatic step(input logic p, input logic v, input int x, input int y);
    @(posedge clk);
    #1;
    p_tick   = p;
    video_on = v;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
  endtask

  task automatic blank_cycles(input int n);
    for (int i = 0; i < n; i++) step((i % 2) == 0, 1'b0, 0, 0);
  endtask

  // One host transaction; p_tick alternates starting at p_first. lat is the
  // ack cycle counted from the accept cycle (-1 if no ack within the budget).
  task automatic host_txn(input logic we, input int addr, input logic [7:0] wdata,
                          input logic p_first, input logic v,
                          output int lat, output logic [7:0] rd, output int we_cnt,
                          output int host_en_cnt, output int pix_nz);
    logic p;
    p = p_first;
    lat = -1; rd = '0; we_cnt = 0; host_en_cnt = 0; pix_nz = 0;
    step(p, v, 8, 5);
    host_req = 1'b1; host_we = we; host_addr = 15'(addr); host_wdata = wdata;
    for (int k = 0; k < 10; k++) begin
      #4;
      if (ram_en && ram_we) we_cnt++;
      if (ram_en && !(p_tick && video_on)) host_en_cnt++;
      if (pix_data != 8'h00) pix_nz++;
      if (host_ack) begin
        lat = k;
        rd  = host_rdata;
        break;
      end
      p = ~p;
      step(p, v, 8, 5);
    end
    p = ~p;
    step(p, v, 8, 5);
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  typedef struct {
    logic p, v;
    int   x, y;
    logic en, we;
    int   addr;
  } vec_t;

  vec_t vecs [9];
  int   lines [14] = '{0, 1, 2, 3, 4, 5, 476, 477, 478, 479, 480, 481, 523, 524};

  int          lat, wec, hen, pnz, acks_seen;
  logic [7:0]  rd;
  int          bad, wr_strobes, n_acks, tmo, lat_min, lat_max;
  logic        frame_done;
  logic [14:0] waddr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1,    8,    5, 1'b1, 1'b0,   162};
    vecs[1] = '{1'b1, 1'b1,    0,    0, 1'b1, 1'b0,     0};
    vecs[2] = '{1'b1, 1'b1,  639,  479, 1'b1, 1'b0, 19199};
    vecs[3] = '{1'b1, 1'b0,    8,    5, 1'b0, 1'b0,     0};
    vecs[4] = '{1'b0, 1'b1,    8,    5, 1'b0, 1'b0,     0};
    vecs[5] = '{1'b1, 1'b1,    4,    4, 1'b1, 1'b0,   161};
    vecs[6] = '{1'b1, 1'b1,    3,    3, 1'b1, 1'b0,     0};
    vecs[7] = '{1'b1, 1'b1,  100,  200, 1'b1, 1'b0,  8025};
    vecs[8] = '{1'b1, 1'b1, 1023, 1023, 1'b1, 1'b0,  8287};

    reset = 1'b1; p_tick = 1'b1; video_on = 1'b1; pixel_x = 10'd8; pixel_y = 10'd5;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    pre_we = 1'b1; pre_addr = 15'd162; pre_data = 8'hA5;
    step(1'b1, 1'b1, 8, 5);
    pre_we = 1'b0;
    step(1'b1, 1'b1, 8, 5);
    #4;
    check("rst_host_ack", host_ack, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_host_rdata", host_rdata, 0);
    step(1'b0, 1'b0, 0, 0);
    reset = 1'b0;

    // Display addressing, host idle.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].p, vecs[i].v, vecs[i].x, vecs[i].y);
      #4;
      check($sformatf("vec%0d_ram_en", i), ram_en, vecs[i].en);
      check($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].we);
      check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].addr);
    end

    // Pixel pipeline: slot at x=8,y=5 shows 0xA5 exactly two clocks later.
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 8, 5); #4; check("pipe_slot_cycle", pix_data, 8'h00);
    step(1'b0, 1'b1, 8, 5); #4; check("pipe_plus1", pix_data, 8'h00);
    step(1'b1, 1'b1, 0, 0); #4; check("pipe_plus2", pix_data, 8'hA5);
    step(1'b0, 1'b1, 0, 0); #4; check("pipe_hold", pix_data, 8'hA5);

    // Host writes: accepted on a display slot vs. a host slot.
    host_txn(1'b1, 16'h0010, 8'h3C, 1'b1, 1'b1, lat, rd, wec, hen, pnz);
    check("wr10_lat", lat, 2);
    check("wr10_we_strobes", wec, 1);
    check("wr10_host_strobes", hen, 1);
    host_txn(1'b1, 16'h0020, 8'hC3, 1'b0, 1'b1, lat, rd, wec, hen, pnz);
    check("wr20_lat", lat, 3);

    // Host reads during blanking and during visible area.
    blank_cycles(4);
    host_txn(1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, lat, rd, wec, hen, pnz);
    check("rd10_lat", lat, 3);
    check("rd10_data", rd, 8'h3C);
    check("rd10_we_strobes", wec, 0);
    check("rd10_pix_nonzero", pnz, 0);
    host_txn(1'b0, 16'h0020, 8'h00, 1'b0, 1'b1, lat, rd, wec, hen, pnz);
    check("rd20_lat", lat, 4);
    check("rd20_data", rd, 8'hC3);

    // Out-of-range and last in-range address.
    host_txn(1'b1, 19200, 8'hFF, 1'b1, 1'b1, lat, rd, wec, hen, pnz);
    check("wr_oor_lat", lat, 2);
    check("wr_oor_we_strobes", wec, 0);
    check("wr_oor_host_strobes", hen, 0);
    host_txn(1'b0, 19200, 8'h00, 1'b1, 1'b0, lat, rd, wec, hen, pnz);
    check("rd_oor_lat", lat, 3);
    check("rd_oor_data", rd, 8'h00);
    check("rd_oor_host_strobes", hen, 0);
    host_txn(1'b1, 19199, 8'h77, 1'b1, 1'b0, lat, rd, wec, hen, pnz);
    check("wr_last_we_strobes", wec, 1);
    host_txn(1'b0, 19199, 8'h00, 1'b0, 1'b0, lat, rd, wec, hen, pnz);
    check("rd_last_data", rd, 8'h77);

    // Reset while the FSM sits in RDWAIT.
    step(1'b1, 1'b1, 8, 5);
    host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0010;
    step(1'b0, 1'b1, 8, 5);
    step(1'b0, 1'b0, 0, 0);
    reset = 1'b1; host_req = 1'b0;
    #4;
    check("rstrd_pix_before", pix_data, 8'hA5);
    step(1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    #4;
    check("rstrd_host_ack", host_ack, 0);
    check("rstrd_ram_en", ram_en, 0);
    check("rstrd_pix_data", pix_data, 0);
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 0, 0);
      #4;
      if (host_ack) acks_seen++;
    end
    check("rstrd_stale_acks", acks_seen, 0);
    host_txn(1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, lat, rd, wec, hen, pnz);
    check("rstrd_after_lat", lat, 3);
    check("rstrd_after_data", rd, 8'h3C);

    // Partial frame sweep with back-to-back host writes.
    bad = 0; wr_strobes = 0; n_acks = 0; tmo = 0; lat_min = 99; lat_max = 0;
    frame_done = 1'b0; waddr = 15'd1000;
    fork
      begin : sync_gen
        int exp_addr;
        for (int li = 0; li < 14; li++) begin
          for (int x = 0; x < 800; x++) begin
            for (int ph = 0; ph < 2; ph++) begin
              step(ph == 0, (x < 640) && (lines[li] < 480), x, lines[li]);
              #4;
              if (p_tick && video_on) begin
                exp_addr = (lines[li] / 4) * 160 + x / 4;
                if (!(ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === 15'(exp_addr))) bad++;
              end
            end
          end
        end
        frame_done = 1'b1;
      end
      begin : host_agent
        int  c0, l;
        bit  stop;
        @(posedge clk);
        #1;
        host_we = 1'b1; host_addr = waddr; host_wdata = waddr[7:0] ^ 8'h5A;
        host_req = 1'b1; c0 = cyc; stop = 1'b0;
        while (!stop) begin
          #4;
          if (ram_en && ram_we) wr_strobes++;
          if (host_ack) begin
            l = cyc - c0;
            if (l < lat_min) lat_min = l;
            if (l > lat_max) lat_max = l;
            n_acks++;
            @(posedge clk);
            #1;
            if (frame_done) begin
              host_req = 1'b0; host_we = 1'b0; stop = 1'b1;
            end else begin
              waddr = waddr + 15'd1;
              host_addr = waddr; host_wdata = waddr[7:0] ^ 8'h5A; c0 = cyc;
            end
          end else if (cyc - c0 > 8) begin
            tmo++; host_req = 1'b0; stop = 1'b1;
          end else begin
            @(posedge clk);
            #1;
          end
        end
      end
    join
    check("frame_display_slots_bad", bad, 0);
    check("frame_ack_timeouts", tmo, 0);
    check("frame_ack_latency_2_to_3", (lat_min >= 2) && (lat_max <= 3), 1);
    check("frame_many_acks", n_acks > 4000, 1);
    check("frame_write_strobes", wr_strobes, n_acks);

    host_txn(1'b0, 1000, 8'h00, 1'b1, 1'b0, lat, rd, wec, hen, pnz);
    check("frame_rd_first", rd, 8'hB2);
    host_txn(1'b0, int'(waddr), 8'h00, 1'b1, 1'b0, lat, rd, wec, hen, pnz);
    check("frame_rd_last", rd, waddr[7:0] ^ 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
